// File: rtl/led_sched_pkg.sv
// ============================================================================
// Module  : led_sched_pkg
// Brief   : Shared state encoding and constants for the LED bank scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package led_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    localparam logic [24:0] SLOT_CYCLES_DEF = 25'd12_000_000;
    localparam logic [15:0] LED_OFF         = 16'hffff;

endpackage

`default_nettype wire

// File: rtl/led_rr_pick.sv
// ============================================================================
// Module  : led_rr_pick
// Brief   : Combinational round-robin picker; first set req after 'last'.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic             hit,
    output logic [IDW-1:0]   idx
);

    logic [IDW-1:0] w_cand;

    // Scan last+1 .. last+N_REQ with wrap; the previous owner is considered last.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDW'((int'(last) + k) % N_REQ);
            if (!hit && req[w_cand]) begin
                hit = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_bank_sched.sv
// ============================================================================
// Module  : led_bank_sched
// Brief   : Round-robin time-slice owner of the active-low 16-bit LED bank.
//           Optional owner-change dead cycle: define LED_SCHED_BLANK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_bank_sched
    import led_sched_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter logic [24:0] SLOT_CYCLES  = SLOT_CYCLES_DEF,
    parameter logic [15:0] IDLE_PATTERN = LED_OFF,
    localparam int         IDW          = $clog2(N_REQ)
) (
    input  logic                 clk_24m,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [IDW-1:0]       owner_id,
    output logic [15:0]          led
);

    state_e            r_state_q, w_state_d;
    logic [IDW-1:0]    r_owner_q, w_owner_d;
    logic [IDW-1:0]    r_last_q,  w_last_d;
    logic [24:0]       r_slot_q,  w_slot_d;
    logic [N_REQ-1:0]  r_gnt_q,   w_gnt_d;
    logic [15:0]       r_led_q,   w_led_d;

    logic              w_hit;
    logic [IDW-1:0]    w_pick;
    logic              w_take;
    logic              w_others;
    logic [N_REQ-1:0]  w_owner_oh;

    led_rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req  (req),
        .last (r_last_q),
        .hit  (w_hit),
        .idx  (w_pick)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_owner_d  = r_owner_q;
        w_last_d   = r_last_q;
        w_slot_d   = r_slot_q;
        w_take     = 1'b0;
        w_owner_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_owner_q == IDW'(i)) begin
                w_owner_oh[i] = 1'b1;
            end
        end
        w_others = |(req & ~w_owner_oh);

        case (r_state_q)
            ST_IDLE: begin
                if (w_hit) begin
                    w_take = 1'b1;
                end
            end
            ST_OWN: begin
                // An owner dropping its request wins over a coincident expiry.
                if (!req[r_owner_q]) begin
`ifdef LED_SCHED_BLANK_EN
                    w_state_d = ST_BLANK;
`else
                    if (w_hit) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_d = ST_IDLE;
                    end
`endif
                end else if (r_slot_q == SLOT_CYCLES - 25'd1) begin
                    if (w_others) begin
`ifdef LED_SCHED_BLANK_EN
                        w_state_d = ST_BLANK;
`else
                        w_take = 1'b1;
`endif
                    end else begin
                        w_slot_d = '0;
                    end
                end else begin
                    w_slot_d = r_slot_q + 25'd1;
                end
            end
`ifdef LED_SCHED_BLANK_EN
            ST_BLANK: begin
                if (w_hit) begin
                    w_take = 1'b1;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (w_take) begin
            w_state_d = ST_OWN;
            w_owner_d = w_pick;
            w_last_d  = w_pick;
            w_slot_d  = '0;
        end

        // Outputs are registered from the next state so grant and data land together.
        w_gnt_d = '0;
        w_led_d = IDLE_PATTERN;
        if (w_state_d == ST_OWN) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_owner_d == IDW'(i)) begin
                    w_gnt_d[i] = 1'b1;
                    w_led_d    = req_data[16*i +: 16];
                end
            end
        end
    end

    always_ff @(posedge clk_24m) begin
        if (!rst_n) begin
            r_state_q <= ST_IDLE;
            r_owner_q <= '0;
            r_last_q  <= IDW'(N_REQ - 1);
            r_slot_q  <= '0;
            r_gnt_q   <= '0;
            r_led_q   <= IDLE_PATTERN;
        end else begin
            r_state_q <= w_state_d;
            r_owner_q <= w_owner_d;
            r_last_q  <= w_last_d;
            r_slot_q  <= w_slot_d;
            r_gnt_q   <= w_gnt_d;
            r_led_q   <= w_led_d;
        end
    end

    assign gnt      = r_gnt_q;
    assign owner_id = r_owner_q;
    assign led      = r_led_q;

endmodule

`default_nettype wire
